// File: rtl/pre_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pre_load_ctrl
// Description : Boot-time preload sequencer. Reads a byte-wide block ROM
//               (1-cycle read latency), packs bytes little-endian into
//               32-bit words and writes them to SRAM over an OBI-style
//               master port, then raises CPU fetch enable.
// Revision    : 1.0 - initial release
// ============================================================================
module pre_load_ctrl #(
    parameter int unsigned NUM_BYTES  = 100000,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic [31:0] rom_addr_o,
    input  logic [7:0]  rom_data_i,
    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    output logic [31:0] bus_addr_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        fetch_enable_o,
    output logic [31:0] words_written_o
);

    localparam logic [31:0] c_num_bytes = 32'(NUM_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WRITE    = 3'd2,
        ST_WAIT_RSP = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_p;          // byte pointer of the word being assembled
    logic [31:0] r_w;          // destination word index
    logic [31:0] r_words;      // completed word writes
    logic [31:0] r_rom_addr;
    logic [31:0] r_pack;
    logic [2:0]  r_cyc;        // cycle index inside READ (0..lanes)

    logic [31:0] w_remaining;
    logic [2:0]  w_lanes;
    logic [31:0] w_p_next;
    logic        w_last;
    logic        w_start;
    logic [3:0]  w_be;

    // Per-word lane count and the pointer after this word completes
    always_comb begin
        w_remaining = c_num_bytes - r_p;
        w_lanes     = (w_remaining >= 32'd4) ? 3'd4 : w_remaining[2:0];
        w_p_next    = r_p + {29'd0, w_lanes};
        w_last      = (w_p_next >= c_num_bytes);
        w_start     = AUTO_START ? 1'b1 : start_i;
        case (w_lanes)
            3'd4:    w_be = 4'hF;
            3'd3:    w_be = 4'h7;
            3'd2:    w_be = 4'h3;
            3'd1:    w_be = 4'h1;
            default: w_be = 4'h0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived outputs
    always_comb begin
        w_state_next = r_state;
        bus_req_o    = 1'b0;
        bus_we_o     = 1'b0;
        bus_addr_o   = 32'd0;
        bus_be_o     = 4'h0;
        bus_wdata_o  = 32'd0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = (c_num_bytes == 32'd0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                busy_o = 1'b1;
                if (r_cyc == w_lanes) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                busy_o      = 1'b1;
                bus_req_o   = 1'b1;
                bus_we_o    = 1'b1;
                bus_addr_o  = BASE_ADDR + (r_w << 2);
                bus_be_o    = w_be;
                bus_wdata_o = r_pack;
                if (bus_gnt_i) begin
                    w_state_next = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                busy_o = 1'b1;
                if (bus_rvalid_i) begin
                    w_state_next = w_last ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: ROM address walk, byte packing, pointers and counters
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_p        <= 32'd0;
            r_w        <= 32'd0;
            r_words    <= 32'd0;
            r_rom_addr <= 32'd0;
            r_pack     <= 32'd0;
            r_cyc      <= 3'd0;
        end else begin
            case (r_state)
                ST_READ: begin
                    // Address for lane k is on the bus in READ cycle k;
                    // its data arrives and is captured in cycle k+1.
                    if ({1'b0, r_cyc} + 4'd1 < {1'b0, w_lanes}) begin
                        r_rom_addr <= r_rom_addr + 32'd1;
                    end
                    case (r_cyc)
                        3'd1:    r_pack[7:0]   <= rom_data_i;
                        3'd2:    r_pack[15:8]  <= rom_data_i;
                        3'd3:    r_pack[23:16] <= rom_data_i;
                        3'd4:    r_pack[31:24] <= rom_data_i;
                        default: ;
                    endcase
                    if (r_cyc == w_lanes) begin
                        r_cyc <= 3'd0;
                    end else begin
                        r_cyc <= r_cyc + 3'd1;
                    end
                end
                ST_WAIT_RSP: begin
                    if (bus_rvalid_i) begin
                        r_words <= r_words + 32'd1;
                        r_w     <= r_w + 32'd1;
                        r_p     <= w_p_next;
                        r_pack  <= 32'd0;
                        // Leave the address parked on the final byte once done
                        if (!w_last) begin
                            r_rom_addr <= w_p_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr_o      = r_rom_addr;
    assign fetch_enable_o  = done_o;
    assign words_written_o = r_words;

endmodule
`default_nettype wire

// File: tb/tb_pre_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pre_load_ctrl
// Description : Self-checking bench for pre_load_ctrl. Three instances:
//               A (8 bytes, auto start), B (6 bytes, manual start),
//               C (empty image).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pre_load_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        int gnt_delay;
        int rsp_lat;
        bit stray;
        int exp_cycles;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ROM image is 00,01,02,... at byte address i
    function automatic logic [7:0] rom_byte(input logic [31:0] a);
        return a[7:0];
    endfunction

    // ---------------- instance A: NUM_BYTES=8, auto start ----------------
    logic        a_rst_n = 1'b0;
    logic        a_start = 1'b0;
    logic [31:0] a_rom_addr;
    logic [7:0]  a_rom_data;
    logic        a_req, a_gnt = 1'b0, a_we, a_rvalid = 1'b0;
    logic [31:0] a_addr, a_wdata, a_words;
    logic [3:0]  a_be;
    logic        a_busy, a_done, a_fe;

    pre_load_ctrl #(.NUM_BYTES(8), .BASE_ADDR(32'h0000_1000), .AUTO_START(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(a_rst_n), .start_i(a_start),
        .rom_addr_o(a_rom_addr), .rom_data_i(a_rom_data),
        .bus_req_o(a_req), .bus_gnt_i(a_gnt), .bus_addr_o(a_addr), .bus_we_o(a_we),
        .bus_be_o(a_be), .bus_wdata_o(a_wdata), .bus_rvalid_i(a_rvalid),
        .busy_o(a_busy), .done_o(a_done), .fetch_enable_o(a_fe), .words_written_o(a_words)
    );

    always @(posedge clk) a_rom_data <= rom_byte(a_rom_addr);

    int  a_gnt_delay = 0;
    int  a_rsp_lat = 1;
    bit  a_stray = 1'b0;
    int  a_wait_cnt = 0;
    int  a_rsp_cnt = 0;
    bit  a_pending = 1'b0;
    bit  a_stray_fired = 1'b0;
    logic [31:0] a_snap_addr, a_snap_data, a_snap_rom;
    logic [3:0]  a_snap_be;
    wr_t a_log[$];

    // Bus slave for A: programmable grant delay, response latency, stray pulses
    always @(negedge clk) begin
        wr_t e;
        a_gnt    = 1'b0;
        a_rvalid = 1'b0;
        if (!a_rst_n) begin
            a_rsp_cnt     = 0;
            a_pending     = 1'b0;
            a_wait_cnt    = 0;
            a_stray_fired = 1'b0;
        end else begin
            if (a_rsp_cnt > 0) begin
                a_rsp_cnt--;
                if (a_rsp_cnt == 0) begin
                    a_rvalid      = 1'b1;
                    a_pending     = 1'b0;
                    a_stray_fired = 1'b0;
                end
            end
            if (a_req) begin
                if (a_wait_cnt == 0) begin
                    a_snap_addr = a_addr;
                    a_snap_data = a_wdata;
                    a_snap_be   = a_be;
                    a_snap_rom  = a_rom_addr;
                end else begin
                    check("hold_addr", a_addr, a_snap_addr);
                    check("hold_wdata", a_wdata, a_snap_data);
                    check("hold_be", {28'd0, a_be}, {28'd0, a_snap_be});
                    check("hold_rom_addr", a_rom_addr, a_snap_rom);
                end
                if (a_wait_cnt < a_gnt_delay) begin
                    a_wait_cnt++;
                end else begin
                    a_gnt  = 1'b1;
                    e.addr = a_addr;
                    e.data = a_wdata;
                    e.be   = a_be;
                    a_log.push_back(e);
                    check("we_with_req", {31'd0, a_we}, 32'd1);
                    a_rsp_cnt  = a_rsp_lat;
                    a_pending  = 1'b1;
                    a_wait_cnt = 0;
                end
            end else if (a_stray && a_busy && !a_pending && !a_rvalid && !a_stray_fired) begin
                a_gnt         = 1'b1;
                a_rvalid      = 1'b1;
                a_stray_fired = 1'b1;
            end
        end
    end

    // ---------------- instance B: NUM_BYTES=6, manual start ----------------
    logic        b_rst_n = 1'b0;
    logic        b_start = 1'b0;
    logic [31:0] b_rom_addr;
    logic [7:0]  b_rom_data;
    logic        b_req, b_gnt = 1'b0, b_we, b_rvalid = 1'b0;
    logic [31:0] b_addr, b_wdata, b_words;
    logic [3:0]  b_be;
    logic        b_busy, b_done, b_fe;
    bit          b_rsp_pend = 1'b0;
    wr_t         b_log[$];

    pre_load_ctrl #(.NUM_BYTES(6), .BASE_ADDR(32'h0000_1000), .AUTO_START(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(b_rst_n), .start_i(b_start),
        .rom_addr_o(b_rom_addr), .rom_data_i(b_rom_data),
        .bus_req_o(b_req), .bus_gnt_i(b_gnt), .bus_addr_o(b_addr), .bus_we_o(b_we),
        .bus_be_o(b_be), .bus_wdata_o(b_wdata), .bus_rvalid_i(b_rvalid),
        .busy_o(b_busy), .done_o(b_done), .fetch_enable_o(b_fe), .words_written_o(b_words)
    );

    always @(posedge clk) b_rom_data <= rom_byte(b_rom_addr);

    // Bus slave for B: immediate grant, response one cycle later
    always @(negedge clk) begin
        wr_t e;
        b_gnt    = 1'b0;
        b_rvalid = 1'b0;
        if (!b_rst_n) begin
            b_rsp_pend = 1'b0;
        end else begin
            if (b_rsp_pend) begin
                b_rvalid   = 1'b1;
                b_rsp_pend = 1'b0;
            end
            if (b_req) begin
                b_gnt  = 1'b1;
                e.addr = b_addr;
                e.data = b_wdata;
                e.be   = b_be;
                b_log.push_back(e);
                b_rsp_pend = 1'b1;
            end
        end
    end

    // ---------------- instance C: NUM_BYTES=0 ----------------
    logic        c_rst_n = 1'b0;
    logic        c_start = 1'b0;
    logic [31:0] c_rom_addr, c_addr, c_wdata, c_words;
    logic        c_req, c_we, c_busy, c_done, c_fe;
    logic [3:0]  c_be;
    logic [7:0]  c_rom_data = 8'h00;
    logic        c_gnt = 1'b0, c_rvalid = 1'b0;

    pre_load_ctrl #(.NUM_BYTES(0), .BASE_ADDR(32'h0000_1000), .AUTO_START(1'b1)) dut_c (
        .clk_i(clk), .rst_ni(c_rst_n), .start_i(c_start),
        .rom_addr_o(c_rom_addr), .rom_data_i(c_rom_data),
        .bus_req_o(c_req), .bus_gnt_i(c_gnt), .bus_addr_o(c_addr), .bus_we_o(c_we),
        .bus_be_o(c_be), .bus_wdata_o(c_wdata), .bus_rvalid_i(c_rvalid),
        .busy_o(c_busy), .done_o(c_done), .fetch_enable_o(c_fe), .words_written_o(c_words)
    );

    task automatic check_a_zero(input string tag);
        check({tag, "_rom_addr"}, a_rom_addr, 32'd0);
        check({tag, "_req"}, {31'd0, a_req}, 32'd0);
        check({tag, "_bus_addr"}, a_addr, 32'd0);
        check({tag, "_we"}, {31'd0, a_we}, 32'd0);
        check({tag, "_be"}, {28'd0, a_be}, 32'd0);
        check({tag, "_wdata"}, a_wdata, 32'd0);
        check({tag, "_busy"}, {31'd0, a_busy}, 32'd0);
        check({tag, "_done"}, {31'd0, a_done}, 32'd0);
        check({tag, "_fetch_en"}, {31'd0, a_fe}, 32'd0);
        check({tag, "_words"}, a_words, 32'd0);
    endtask

    task automatic a_reset();
        @(negedge clk);
        a_rst_n    = 1'b0;
        a_rsp_cnt  = 0;
        a_pending  = 1'b0;
        a_wait_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_log.delete();
        a_rst_n = 1'b1;
    endtask

    initial begin
        vec_t        vecs[5];
        logic [31:0] exp_addr[2];
        logic [31:0] exp_data[2];
        logic [3:0]  exp_be[2];
        int          cycles;
        int          req_seen;

        vecs[0] = '{gnt_delay: 0, rsp_lat: 1, stray: 1'b0, exp_cycles: 15};
        vecs[1] = '{gnt_delay: 5, rsp_lat: 1, stray: 1'b0, exp_cycles: 25};
        vecs[2] = '{gnt_delay: 0, rsp_lat: 4, stray: 1'b1, exp_cycles: 21};
        vecs[3] = '{gnt_delay: 2, rsp_lat: 3, stray: 1'b1, exp_cycles: 23};
        vecs[4] = '{gnt_delay: 1, rsp_lat: 2, stray: 1'b0, exp_cycles: 19};
        exp_addr[0] = 32'h0000_1000; exp_data[0] = 32'h0302_0100; exp_be[0] = 4'hF;
        exp_addr[1] = 32'h0000_1004; exp_data[1] = 32'h0706_0504; exp_be[1] = 4'hF;

        // Reset values on all instances
        repeat (2) @(posedge clk);
        #1;
        check_a_zero("rst");
        check("rst_b_done", {31'd0, b_done}, 32'd0);
        check("rst_c_done", {31'd0, c_done}, 32'd0);

        // Empty image: straight to DONE, no traffic
        @(negedge clk);
        c_rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("empty_done", {31'd0, c_done}, 32'd1);
        check("empty_fetch_en", {31'd0, c_fe}, 32'd1);
        check("empty_busy", {31'd0, c_busy}, 32'd0);
        check("empty_req", {31'd0, c_req}, 32'd0);
        check("empty_words", c_words, 32'd0);

        // Table-driven copies on instance A
        for (int i = 0; i < 5; i++) begin
            a_gnt_delay = vecs[i].gnt_delay;
            a_rsp_lat   = vecs[i].rsp_lat;
            a_stray     = vecs[i].stray;
            a_reset();
            cycles = 0;
            while (!a_done && cycles < 200) begin
                @(posedge clk);
                #1;
                cycles++;
            end
            check($sformatf("v%0d_done_cycle", i), cycles, vecs[i].exp_cycles);
            check($sformatf("v%0d_nwrites", i), a_log.size(), 32'd2);
            if (a_log.size() >= 2) begin
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("v%0d_w%0d_addr", i, k), a_log[k].addr, exp_addr[k]);
                    check($sformatf("v%0d_w%0d_data", i, k), a_log[k].data, exp_data[k]);
                    check($sformatf("v%0d_w%0d_be", i, k), {28'd0, a_log[k].be}, {28'd0, exp_be[k]});
                end
            end
            check($sformatf("v%0d_words", i), a_words, 32'd2);
            check($sformatf("v%0d_fetch_en", i), {31'd0, a_fe}, 32'd1);
            check($sformatf("v%0d_busy", i), {31'd0, a_busy}, 32'd0);
            check($sformatf("v%0d_rom_addr_hold", i), a_rom_addr, 32'd7);
        end
        a_stray = 1'b0;

        // Reset during WAIT_RSP of word 1
        a_gnt_delay = 0;
        a_rsp_lat   = 4;
        a_reset();
        cycles = 0;
        while (a_log.size() < 2 && cycles < 100) begin
            @(posedge clk);
            cycles++;
        end
        check("midrst_reached_w1", a_log.size(), 32'd2);
        #1;
        check("midrst_words_before", a_words, 32'd1);
        @(negedge clk);
        a_rst_n    = 1'b0;
        a_rsp_cnt  = 0;
        a_pending  = 1'b0;
        a_wait_cnt = 0;
        @(posedge clk);
        #1;
        check_a_zero("midrst");
        @(negedge clk);
        a_log.delete();
        a_rst_n   = 1'b1;
        a_rsp_lat = 1;
        @(posedge clk);
        #1;
        check("restart_busy", {31'd0, a_busy}, 32'd1);
        check("restart_rom_addr", a_rom_addr, 32'd0);
        cycles = 1;
        while (!a_done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("restart_done_cycle", cycles, 32'd15);
        check("restart_nwrites", a_log.size(), 32'd2);
        if (a_log.size() >= 1) begin
            check("restart_first_addr", a_log[0].addr, 32'h0000_1000);
        end
        check("restart_words", a_words, 32'd2);

        // Manual start with a 6-byte image
        @(negedge clk);
        b_rst_n  = 1'b1;
        req_seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (b_req || b_busy) req_seen++;
        end
        check("manual_idle_no_req", req_seen, 32'd0);
        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk);
        #1;
        cycles = 1;
        @(negedge clk);
        b_start = 1'b0;
        while (!b_done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("manual_done_cycle", cycles, 32'd13);
        check("tail_nwrites", b_log.size(), 32'd2);
        if (b_log.size() >= 2) begin
            check("tail_w0_addr", b_log[0].addr, 32'h0000_1000);
            check("tail_w0_data", b_log[0].data, 32'h0302_0100);
            check("tail_w0_be", {28'd0, b_log[0].be}, 32'h0000_000F);
            check("tail_w1_addr", b_log[1].addr, 32'h0000_1004);
            check("tail_w1_data", b_log[1].data, 32'h0000_0504);
            check("tail_w1_be", {28'd0, b_log[1].be}, 32'h0000_0003);
        end
        check("tail_words", b_words, 32'd2);
        check("tail_rom_addr_hold", b_rom_addr, 32'd5);
        repeat (5) @(posedge clk);
        #1;
        check("tail_no_third_req", b_log.size(), 32'd2);
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("post_done_start_done", {31'd0, b_done}, 32'd1);
        check("post_done_start_fe", {31'd0, b_fe}, 32'd1);
        check("post_done_start_busy", {31'd0, b_busy}, 32'd0);
        check("post_done_start_nwrites", b_log.size(), 32'd2);
        check("post_done_start_words", b_words, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pre_load_ctrl.md
Name: pre_load_ctrl

Overview:
- Boot-time preload sequencer for the byte-wide, pre-initialised block ROM (1-cycle read latency, always enabled).
- Walks the ROM image byte by byte and packs four bytes little-endian into 32-bit words.
- Writes each word into system SRAM through a single OBI-style master port.
- Releases CPU fetch enable once the whole image is copied. Sits between the ROM and the bus crossbar, active only after reset.

Parameters:
- NUM_BYTES, 100000, image size in bytes; must match the ROM depth; need not be a multiple of 4.
- BASE_ADDR, 32'h0000_0000, bus address of the first destination word; must be word-aligned.
- AUTO_START, 1, 1 = start the copy on the first cycle after reset; 0 = wait for start_i.

Ports:
- clk_i  input  1  sole clock
- rst_ni  input  1  synchronous, active-low reset
- start_i  input  1  start request; sampled only in IDLE when AUTO_START=0
- rom_addr_o  output  32  byte address to ROM
- rom_data_i  input  8  ROM read data; valid one cycle after rom_addr_o
- bus_req_o  output  1  OBI request
- bus_gnt_i  input  1  OBI grant
- bus_addr_o  output  32  OBI word address
- bus_we_o  output  1  write enable; always 1 while bus_req_o=1
- bus_be_o  output  4  byte enables
- bus_wdata_o  output  32  write data
- bus_rvalid_i  input  1  OBI response valid
- busy_o  output  1  copy in progress
- done_o  output  1  copy complete; sticky until reset
- fetch_enable_o  output  1  CPU fetch enable; equals done_o
- words_written_o  output  32  count of completed (rvalid) word writes

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk_i.
  - rst_ni=0 at an edge forces state IDLE and clears all counters and the pack register.
  - Every output resets to 0: rom_addr_o, all bus_* outputs, busy_o, done_o, fetch_enable_o, words_written_o.
- States: IDLE, READ, WRITE, WAIT_RSP, DONE.
- IDLE:
  - AUTO_START=1: go to READ on the first edge with rst_ni=1.
  - AUTO_START=0: go to READ on an edge with start_i=1.
  - Byte pointer p=0, word index w=0.
- READ:
  - lanes = min(4, NUM_BYTES-p).
  - For k=0..lanes-1, drive rom_addr_o=p+k on consecutive cycles.
  - Capture rom_data_i in the cycle after each address into pack[8k+7:8k].
  - Unused lanes are 0. READ lasts lanes+1 cycles. rom_addr_o holds its last value outside READ.
- WRITE:
  - Drive bus_req_o=1, bus_we_o=1, bus_addr_o=BASE_ADDR+4*w, bus_wdata_o=pack.
  - bus_be_o = lanes-hot from bit 0 (4→4'hF, 3→4'h7, 2→4'h3, 1→4'h1).
  - All bus outputs remain stable while bus_gnt_i=0.
  - Go to WAIT_RSP on the edge where bus_gnt_i=1; bus_req_o drops next cycle.
- WAIT_RSP:
  - Exactly one outstanding transaction. The response (bus_rvalid_i) is accepted in WAIT_RSP only; it is never taken in the same cycle as the grant, so minimum response latency is 1 cycle.
  - On bus_rvalid_i=1: words_written_o++, w++, p+=lanes.
  - If p(new) >= NUM_BYTES go to DONE, else go to READ.
- DONE:
  - done_o=1, fetch_enable_o=1, busy_o=0. Terminal state; start_i is ignored. Left only by reset.
- busy_o=1 in READ, WRITE and WAIT_RSP.
- Arithmetic and widths:
  - p, w and bus_addr_o are 32-bit unsigned; no wrap occurs within the legal NUM_BYTES range.
- Edge cases:
  - NUM_BYTES=0: IDLE goes directly to DONE with no bus traffic.
  - bus_rvalid_i outside WAIT_RSP is ignored.
  - bus_gnt_i outside WRITE is ignored.
  - Reset mid-transfer abandons the word in flight; no further bus_req_o until restart.
- Timing: full-word throughput is 7 cycles per word with immediate grant and 1-cycle response (5 READ + 1 WRITE + 1 WAIT_RSP).

Test Plan:
- Nominal copy. NUM_BYTES=8, BASE_ADDR=0x1000, ROM=00..07, gnt same cycle, rvalid +1.
  → writes (0x1000, 0x03020100, be F) then (0x1004, 0x07060504, be F).
  → done_o=1 at cycle 15 after reset release; words_written_o=2.
- Partial tail. NUM_BYTES=6, same image.
  → second write is (0x1004, 0x00000504, be 3); done_o=1; no third request.
- Grant backpressure. bus_gnt_i held 0 for 5 cycles on word 0.
  → bus_req_o, bus_addr_o, bus_wdata_o, bus_be_o stable across all 5 cycles; rom_addr_o does not advance; single grant accepted.
- Delayed response and stray handshakes. rvalid 4 cycles after gnt, plus a spurious rvalid/gnt pulse while in READ.
  → stray pulses ignored; the next READ starts only after the real rvalid; words_written_o increments once per word.
- Reset mid-copy. rst_ni=0 for 1 cycle during WAIT_RSP of word 1.
  → next cycle all outputs are 0 and state is IDLE; with AUTO_START=1 the copy restarts at 0x1000 and rom_addr_o=0.
- Manual start. AUTO_START=0, start_i low for 10 cycles, then pulsed; a second pulse is given after done.
  → no bus_req_o during the 10 low cycles; copy runs after the pulse; the pulse after done has no effect and done_o stays 1.
